uart_tx_fifo: RTL and testbench

Buffered 8N1 UART transmitter that serialises bytes written by the control-side UART bridge onto the board serial line. Sits directly downstream of the CHDR-to-UART bridge: the bridge pushes one byte per accepted body beat and throttles itself on `fifo_full`. Bit rate is set by a system-clock divider supplied per frame.

---
 rtl/uart_tx_fifo_if.sv | 24 ++
 rtl/uart_tx_fifo.sv | 125 ++++++++++++
 tb/tb_uart_tx_fifo.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_fifo_if.sv
// Byte-side and line-side signals of the buffered UART transmitter.
// The master is the upstream byte source; the slave is the transmitter.
interface uart_tx_fifo_if #(
    parameter int SIZE = 4
);
    logic [7:0]  fifo_in;
    logic        fifo_write;
    logic        fifo_full;
    logic [SIZE:0] fifo_level;
    logic [15:0] clkdiv;
    logic        baudclk;
    logic        tx;
    logic        busy;

    modport master (
        output fifo_in, fifo_write, clkdiv,
        input  fifo_full, fifo_level, baudclk, tx, busy
    );

    modport slave (
        input  fifo_in, fifo_write, clkdiv,
        output fifo_full, fifo_level, baudclk, tx, busy
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: a 2^SIZE-byte FIFO feeding a start/data/stop
// serialiser whose bit period is latched from clkdiv at each frame start.
module uart_tx_fifo #(
    parameter int SIZE = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    uart_tx_fifo_if.slave  bus
);
    localparam int DEPTH = 1 << SIZE;
    localparam logic [SIZE:0] PTR_ONE = {{SIZE{1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [7:0]    mem [DEPTH];
    logic [SIZE:0] wptr, rptr, wptr_nxt, rptr_nxt;
    logic          empty, wr_en, pop, bit_end;
    logic [15:0]   div_new;

    state_t        state;
    logic [15:0]   div;
    logic [15:0]   cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;

    // A zero divider would stall the baud counter, so it behaves as one.
    function automatic logic [15:0] eff_div(input logic [15:0] cd);
        return (cd == 16'd0) ? 16'd1 : cd;
    endfunction

    // Pointer bookkeeping and the pop decision shared by FIFO and FSM.
    always_comb begin
        empty    = (wptr == rptr);
        wr_en    = bus.fifo_write && !bus.fifo_full;
        bit_end  = (cnt == div - 16'd1);
        pop      = !empty && ((state == IDLE) || ((state == STOP) && bit_end));
        wptr_nxt = wr_en ? wptr + PTR_ONE : wptr;
        rptr_nxt = pop   ? rptr + PTR_ONE : rptr;
        div_new  = eff_div(bus.clkdiv);
    end

    // Storage only; a full FIFO refuses the write so the pop slot is never hit.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wptr[SIZE-1:0]] <= bus.fifo_in;
        end
    end

    // Pointers plus registered level and full flag derived from next pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr           <= '0;
            rptr           <= '0;
            bus.fifo_level <= '0;
            bus.fifo_full  <= 1'b0;
        end else begin
            wptr           <= wptr_nxt;
            rptr           <= rptr_nxt;
            bus.fifo_level <= wptr_nxt - rptr_nxt;
            bus.fifo_full  <= (wptr_nxt[SIZE-1:0] == rptr_nxt[SIZE-1:0]) &&
                              (wptr_nxt[SIZE] != rptr_nxt[SIZE]);
        end
    end

    // Shift register loads on pop and moves one bit at each data-bit boundary.
    always_ff @(posedge clk) begin
        if (pop) begin
            shift <= mem[rptr[SIZE-1:0]];
        end else if ((state == DATA) && bit_end) begin
            shift <= shift >> 1;
        end
    end

    // Frame sequencer; tx, busy and baudclk are registered for the next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            div         <= 16'd1;
            cnt         <= '0;
            bit_idx     <= '0;
            bus.tx      <= 1'b1;
            bus.busy    <= 1'b0;
            bus.baudclk <= 1'b0;
        end else if (pop) begin
            state       <= START;
            div         <= div_new;
            cnt         <= '0;
            bus.tx      <= 1'b0;
            bus.busy    <= 1'b1;
            bus.baudclk <= (div_new == 16'd1);
        end else if (state == IDLE) begin
            bus.tx      <= 1'b1;
            bus.busy    <= 1'b0;
            bus.baudclk <= 1'b0;
        end else if (!bit_end) begin
            cnt         <= cnt + 16'd1;
            bus.baudclk <= (cnt + 16'd1 == div - 16'd1);
        end else begin
            cnt         <= '0;
            bus.baudclk <= (div == 16'd1);
            case (state)
                START: begin
                    state   <= DATA;
                    bit_idx <= '0;
                    bus.tx  <= shift[0];
                end
                DATA: begin
                    if (bit_idx == 3'd7) begin
                        state  <= STOP;
                        bus.tx <= 1'b1;
                    end else begin
                        bit_idx <= bit_idx + 3'd1;
                        bus.tx  <= shift[1];
                    end
                end
                default: begin
                    state       <= IDLE;
                    bus.tx      <= 1'b1;
                    bus.busy    <= 1'b0;
                    bus.baudclk <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: records the line every cycle and checks
// captured windows against hand-derived frame timings.
module tb_uart_tx_fifo;
    localparam int SIZE = 2;
    localparam int MAXC = 8192;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   ntests = 0;
    int   nfail = 0;
    int   cyc = 0;
    int   mark;

    logic       cap_tx   [MAXC];
    logic       cap_busy [MAXC];
    logic       cap_baud [MAXC];
    logic       cap_full [MAXC];
    logic [7:0] cap_lvl  [MAXC];

    uart_tx_fifo_if #(.SIZE(SIZE)) bus ();

    uart_tx_fifo #(.SIZE(SIZE)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Line recorder: sample index k holds the state after k rising edges.
    always @(negedge clk) begin
        if (cyc < MAXC) begin
            cap_tx[cyc]   = bus.tx;
            cap_busy[cyc] = bus.busy;
            cap_baud[cyc] = bus.baudclk;
            cap_full[cyc] = bus.fifo_full;
            cap_lvl[cyc]  = 8'(bus.fifo_level);
        end
        cyc++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ntests++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [7:0] b);
        bus.fifo_in    = b;
        bus.fifo_write = 1'b1;
        tick(1);
    endtask

    function automatic int cnt_busy(input int a, input int b);
        int n = 0;
        for (int i = a; i <= b; i++) if (cap_busy[i] === 1'b1) n++;
        return n;
    endfunction

    function automatic int cnt_baud(input int a, input int b);
        int n = 0;
        for (int i = a; i <= b; i++) if (cap_baud[i] === 1'b1) n++;
        return n;
    endfunction

    function automatic int cnt_txlow(input int a, input int b);
        int n = 0;
        for (int i = a; i <= b; i++) if (cap_tx[i] !== 1'b1) n++;
        return n;
    endfunction

    // Mismatching samples of one 10*d-cycle frame starting at index s.
    function automatic int frame_errs(input int s, input int d, input logic [7:0] b);
        int   n = 0;
        int   bi;
        logic ev;
        for (int k = 0; k < 10 * d; k++) begin
            bi = k / d;
            if (bi == 0)      ev = 1'b0;
            else if (bi == 9) ev = 1'b1;
            else              ev = b[bi-1];
            if (cap_tx[s+k] !== ev || cap_busy[s+k] !== 1'b1) n++;
        end
        return n;
    endfunction

    initial begin
        bus.fifo_in    = 8'h00;
        bus.fifo_write = 1'b0;
        bus.clkdiv     = 16'd4;
        tick(1);

        // Reset held with writes toggling
        for (int i = 0; i < 4; i++) begin
            bus.fifo_write = ~bus.fifo_write;
            bus.fifo_in    = 8'(8'h3C + i);
            tick(1);
        end
        bus.fifo_write = 1'b0;
        check("rst_tx", bus.tx, 1);
        check("rst_busy", bus.busy, 0);
        check("rst_level", bus.fifo_level, 0);
        check("rst_full", bus.fifo_full, 0);
        check("rst_baud", bus.baudclk, 0);
        rst_n = 1'b1;
        mark = cyc;
        tick(20);
        check("idle_busy", cnt_busy(mark, mark + 19), 0);
        check("idle_tx", cnt_txlow(mark, mark + 19), 0);

        // Single byte 0xA5 at D=4
        bus.clkdiv = 16'd4;
        mark = cyc;
        put(8'hA5);
        bus.fifo_write = 1'b0;
        tick(50);
        check("one_lvl_w1", cap_lvl[mark+1], 1);
        check("one_busy_w1", cap_busy[mark+1], 0);
        check("one_lvl_w2", cap_lvl[mark+2], 0);
        check("one_frame", frame_errs(mark + 2, 4, 8'hA5), 0);
        check("one_baud_start", cap_baud[mark+5], 1);
        check("one_busy_end", cap_busy[mark+42], 0);
        check("one_baud_cnt", cnt_baud(mark, mark + 50), 10);

        // Overflow: six writes into a four-deep FIFO at D=100
        bus.clkdiv = 16'd100;
        mark = cyc;
        for (int i = 1; i <= 6; i++) put(8'(i));
        bus.fifo_write = 1'b0;
        tick(5020);
        check("ovf_full_w4", cap_full[mark+4], 0);
        check("ovf_full_w5", cap_full[mark+5], 1);
        check("ovf_lvl_w5", cap_lvl[mark+5], 4);
        check("ovf_lvl_w6", cap_lvl[mark+6], 4);
        for (int i = 0; i < 5; i++)
            check($sformatf("ovf_frame%0d", i + 1),
                  frame_errs(mark + 2 + 1000 * i, 100, 8'(i + 1)), 0);
        check("ovf_no6th", cap_busy[mark+5002], 0);
        check("ovf_lvl_end", cap_lvl[mark+5002], 0);

        // Back-to-back 0x00, 0xFF at D=3
        bus.clkdiv = 16'd3;
        mark = cyc;
        put(8'h00);
        put(8'hFF);
        bus.fifo_write = 1'b0;
        tick(70);
        check("b2b_busy_cnt", cnt_busy(mark, mark + 70), 60);
        check("b2b_frame1", frame_errs(mark + 2, 3, 8'h00), 0);
        check("b2b_frame2", frame_errs(mark + 32, 3, 8'hFF), 0);
        check("b2b_busy_end", cap_busy[mark+62], 0);

        // Divider change mid-frame: 0x55 at D=8, then 0x33 at D=2
        bus.clkdiv = 16'd8;
        mark = cyc;
        put(8'h55);
        put(8'h33);
        bus.fifo_write = 1'b0;
        tick(40);
        bus.clkdiv = 16'd2;
        tick(80);
        check("div_frame1", frame_errs(mark + 2, 8, 8'h55), 0);
        check("div_frame2", frame_errs(mark + 82, 2, 8'h33), 0);
        check("div_busy_end", cap_busy[mark+102], 0);
        check("div_baud_cnt", cnt_baud(mark, mark + 110), 20);

        // Asynchronous reset in the middle of a frame
        bus.clkdiv = 16'd4;
        put(8'h00);
        put(8'h00);
        bus.fifo_write = 1'b0;
        tick(10);
        check("mid_tx_pre", bus.tx, 0);
        check("mid_lvl_pre", bus.fifo_level, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_tx", bus.tx, 1);
        check("mid_busy", bus.busy, 0);
        check("mid_level", bus.fifo_level, 0);
        check("mid_baud", bus.baudclk, 0);
        tick(2);
        rst_n = 1'b1;
        mark = cyc;
        tick(60);
        check("mid_after_busy", cnt_busy(mark, mark + 59), 0);
        check("mid_after_tx", cnt_txlow(mark, mark + 59), 0);

        // clkdiv=0 behaves as one cycle per bit
        bus.clkdiv = 16'd0;
        mark = cyc;
        put(8'h80);
        bus.fifo_write = 1'b0;
        tick(20);
        check("d0_frame", frame_errs(mark + 2, 1, 8'h80), 0);
        check("d0_busy_end", cap_busy[mark+12], 0);
        check("d0_baud_cnt", cnt_baud(mark, mark + 20), 10);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
